alu_seq_unit: RTL and testbench

//  Parametrised, registered ALU execution unit. Replaces the flat 8-to-1 op-result select.

---
 rtl/alu_seq_unit_if.sv | 26 ++
 rtl/alu_seq_unit.sv | 161 ++++++++++++++++
 tb/tb_alu_seq_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_unit_if.sv
// Operand/result handshake bundle for alu_seq_unit.
// master = operand source / result consumer, slave = the execution unit.
interface alu_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Registered ALU execution unit with an iterative shift-add multiplier.
// Single-cycle logic ops; MUL takes a fixed WIDTH iterations.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | ready for a new op; single-cycle ops finish on accept
// ST_MUL   | shift-add multiply running, one multiplier bit per cycle
// ST_DONE  | result registered and presented, waiting for out_ready
module alu_seq_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_unit_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     iter_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               carry_q;

  logic               in_ready_c;
  logic               out_valid_c;
  logic               accept;
  logic               is_mul;
  logic               mul_last;

  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [2*WIDTH-1:0] acc_next;

  assign accept   = bus.in_valid && in_ready_c;
  assign is_mul   = (bus.op == 3'b111) && MUL_EN;
  assign mul_last = (iter_q == '0);

  // Single-cycle result and carry for the op presented at accept.
  always_comb begin
    shamt     = bus.b[SHW-1:0];
    add_ext   = {1'b0, bus.a} + {1'b0, bus.b};
    sub_ext   = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.op)
      3'b000: alu_res = bus.a & bus.b;
      3'b001: alu_res = bus.a << shamt;
      3'b010: alu_res = bus.a | bus.b;
      3'b011: alu_res = bus.a ^ bus.b;
      3'b100: begin
        alu_res   = add_ext[WIDTH-1:0];
        alu_carry = add_ext[WIDTH];
      end
      3'b101: begin
        alu_res   = sub_ext[WIDTH-1:0];
        alu_carry = sub_ext[WIDTH];
      end
      3'b110: alu_res = bus.a >> shamt;
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // One shift-add step: conditionally add the shifted multiplicand.
  always_comb begin
    acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = is_mul ? ST_MUL : ST_DONE;
      end
      ST_MUL: begin
        if (mul_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, multiply iterations and result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      iter_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand_q  <= {{WIDTH{1'b0}}, bus.a};
              mplier_q <= bus.b;
              acc_q    <= '0;
              iter_q   <= SHW'(WIDTH - 1);
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
              carry_q  <= alu_carry;
            end
          end
        end
        ST_MUL: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          iter_q   <= iter_q - 1'b1;
          if (mul_last) begin
            result_q <= acc_next[WIDTH-1:0];
            zero_q   <= (acc_next[WIDTH-1:0] == '0);
            carry_q  <= |acc_next[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: an 8-bit multiplier-enabled instance and a
// 16-bit instance without the multiplier, checked against an arithmetic model.
module tb_alu_seq_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_seq_unit_if #(.WIDTH(8))  bus8 ();
  alu_seq_unit_if #(.WIDTH(16)) bus16 ();

  alu_seq_unit #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  alu_seq_unit #(.WIDTH(16), .MUL_EN(1'b0)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: the opcode rules in plain unsigned integer arithmetic.
  task automatic ref_model(input int w, input bit mul_en, input logic [2:0] op,
                           input longint unsigned x, input longint unsigned y,
                           output longint unsigned res, output bit c);
    longint unsigned mask, r;
    int sh;
    mask = (64'd1 << w) - 1;
    sh   = int'(y % longint'(w));
    c    = 1'b0;
    case (op)
      3'd0: r = x & y;
      3'd1: r = x << sh;
      3'd2: r = x | y;
      3'd3: r = x ^ y;
      3'd4: begin r = x + y; c = (r > mask); end
      3'd5: begin r = x + (mask + 1) - y; c = (x >= y); end
      3'd6: r = x >> sh;
      default: begin
        if (mul_en) begin r = x * y; c = (r > mask); end
        else r = 0;
      end
    endcase
    res = r & mask;
  endtask

  // Issue one op on the 8-bit unit, hold out_ready low for 'hold' cycles of
  // out_valid, and return what was presented plus the observed latency.
  task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input int hold,
                      output logic [7:0] res, output logic c, output logic z, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus8.in_ready && guard < 50) begin @(negedge clk); guard++; end
    bus8.in_valid  = 1'b1;
    bus8.op        = op;
    bus8.a         = a;
    bus8.b         = b;
    bus8.out_ready = (hold == 0);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.a        = 8'($urandom);
    bus8.b        = 8'($urandom);
    lat = 1;
    while (!bus8.out_valid && lat < 50) begin @(negedge clk); lat++; end
    res = bus8.result;
    c   = bus8.carry;
    z   = bus8.zero;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check($sformatf("%s_hold%0d_res", tag, k), bus8.result, res);
      check($sformatf("%s_hold%0d_ov", tag, k), bus8.out_valid, 1);
      check($sformatf("%s_hold%0d_ir", tag, k), bus8.in_ready, 0);
    end
    bus8.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_ir"}, bus8.in_ready, 1);
    check({tag, "_idle_ov"}, bus8.out_valid, 0);
  endtask

  task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic c, output logic z, output int lat);
    @(negedge clk);
    bus16.in_valid  = 1'b1;
    bus16.op        = op;
    bus16.a         = a;
    bus16.b         = b;
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    lat = 1;
    while (!bus16.out_valid && lat < 50) begin @(negedge clk); lat++; end
    res = bus16.result;
    c   = bus16.carry;
    z   = bus16.zero;
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         hold;
    logic [7:0] res;
    logic       carry;
    logic       zero;
    int         lat;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [7:0]      r8;
    logic [15:0]     r16;
    logic            c, z;
    int              lat, bad;
    longint unsigned eres;
    bit              ec;

    checks = 0;
    errors = 0;

    vecs[0]  = '{3'b100, 8'hF0, 8'h20, 0, 8'h10, 1'b1, 1'b0, 1};
    vecs[1]  = '{3'b101, 8'h05, 8'h05, 0, 8'h00, 1'b1, 1'b1, 1};
    vecs[2]  = '{3'b101, 8'h03, 8'h05, 0, 8'hFE, 1'b0, 1'b0, 1};
    vecs[3]  = '{3'b001, 8'h81, 8'hF9, 0, 8'h02, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'b110, 8'h80, 8'h07, 0, 8'h01, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'b111, 8'h10, 8'h11, 0, 8'h10, 1'b1, 1'b0, 9};
    vecs[6]  = '{3'b000, 8'hCC, 8'h0F, 5, 8'h0C, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'b010, 8'h0F, 8'hF0, 0, 8'hFF, 1'b0, 1'b0, 1};
    vecs[8]  = '{3'b011, 8'hFF, 8'hFF, 0, 8'h00, 1'b0, 1'b1, 1};
    vecs[9]  = '{3'b001, 8'h5A, 8'h00, 0, 8'h5A, 1'b0, 1'b0, 1};
    vecs[10] = '{3'b111, 8'h00, 8'hFF, 0, 8'h00, 1'b0, 1'b1, 9};
    vecs[11] = '{3'b111, 8'hFF, 8'hFF, 2, 8'h01, 1'b1, 1'b0, 9};
    vecs[12] = '{3'b100, 8'hFF, 8'h01, 0, 8'h00, 1'b1, 1'b1, 1};

    bus8.in_valid  = 1'b0; bus8.op  = '0; bus8.a  = '0; bus8.b  = '0; bus8.out_ready  = 1'b1;
    bus16.in_valid = 1'b0; bus16.op = '0; bus16.a = '0; bus16.b = '0; bus16.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("rst_ov",    bus8.out_valid, 0);
    check("rst_ir",    bus8.in_ready, 1);
    check("rst_res",   bus8.result, 0);
    check("rst_zero",  bus8.zero, 0);
    check("rst_carry", bus8.carry, 0);
    check("rst16_ir",  bus16.in_ready, 1);

    foreach (vecs[i]) begin
      run8($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, r8, c, z, lat);
      check($sformatf("vec%0d_res", i),   r8,  vecs[i].res);
      check($sformatf("vec%0d_carry", i), c,   vecs[i].carry);
      check($sformatf("vec%0d_zero", i),  z,   vecs[i].zero);
      check($sformatf("vec%0d_lat", i),   lat, vecs[i].lat);
    end

    // MUL with in_valid toggling underneath it.
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.op = 3'b111; bus8.a = 8'h10; bus8.b = 8'h11; bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.op = 3'b100; bus8.a = 8'h01; bus8.b = 8'h01;
    lat = 1;
    bad = 0;
    while (!bus8.out_valid && lat < 50) begin
      if (bus8.in_ready) bad++;
      bus8.in_valid = lat[0];
      @(negedge clk);
      lat++;
    end
    bus8.in_valid = 1'b0;
    check("mulbusy_lat",   lat, 9);
    check("mulbusy_ir",    bad, 0);
    check("mulbusy_res",   bus8.result, 8'h10);
    check("mulbusy_carry", bus8.carry, 1);
    @(negedge clk);
    check("mulbusy_idle_ov", bus8.out_valid, 0);
    @(negedge clk);
    check("mulbusy_noghost_ov", bus8.out_valid, 0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.op = 3'b111; bus8.a = 8'hFF; bus8.b = 8'hFF;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("mulrst_ov",  bus8.out_valid, 0);
    check("mulrst_ir",  bus8.in_ready, 1);
    check("mulrst_res", bus8.result, 0);
    check("mulrst_zero", bus8.zero, 0);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.out_valid) bad++;
    end
    check("mulrst_aborted", bad, 0);

    // 16-bit instance without multiplier.
    run16(3'b111, 16'h1234, 16'h5678, r16, c, z, lat);
    check("w16_mul_res", r16, 0);
    check("w16_mul_carry", c, 0);
    check("w16_mul_zero", z, 1);
    check("w16_mul_lat", lat, 1);
    run16(3'b100, 16'hFFFF, 16'h0001, r16, c, z, lat);
    check("w16_add_res", r16, 0);
    check("w16_add_carry", c, 1);
    check("w16_add_zero", z, 1);

    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      run8($sformatf("rnd%0d", i), op, a, b, $urandom_range(0, 2), r8, c, z, lat);
      ref_model(8, 1'b1, op, a, b, eres, ec);
      check($sformatf("rnd%0d_res", i),   r8,  eres);
      check($sformatf("rnd%0d_carry", i), c,   ec);
      check($sformatf("rnd%0d_zero", i),  z,   eres == 0);
      check($sformatf("rnd%0d_lat", i),   lat, (op == 3'b111) ? 9 : 1);
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [15:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      run16(op, a, b, r16, c, z, lat);
      ref_model(16, 1'b0, op, a, b, eres, ec);
      check($sformatf("rnd16_%0d_res", i),   r16, eres);
      check($sformatf("rnd16_%0d_carry", i), c,   ec);
      check($sformatf("rnd16_%0d_lat", i),   lat, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
